// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: table init sweep, GHR-indexed lookup,
// in-flight FIFO, counter update on resolve and misprediction recovery.
//
// Ports:
//   clk, rst_n (sync, active-low)
//   pc_in, lookup_valid -> lookup_ready, predict_taken, RD_index
//   RD_count            : table read data for RD_index
//   resolve_valid, resolve_taken, flush
//   WR_en1/2, WR_index1/2, WR_count1/2 : registered table writes
//   mispredict, init_done
module branch_predict_ctrl #(
  parameter int INDEX_WIDTH = 8,
  parameter int CNT_W       = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pc_in,
  input  logic                   lookup_valid,
  output logic                   lookup_ready,
  output logic                   predict_taken,
  output logic [INDEX_WIDTH-1:0] RD_index,
  input  logic [CNT_W-1:0]       RD_count,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic                   flush,
  output logic                   WR_en1,
  output logic                   WR_en2,
  output logic [INDEX_WIDTH-1:0] WR_index1,
  output logic [INDEX_WIDTH-1:0] WR_index2,
  output logic [CNT_W-1:0]       WR_count1,
  output logic [CNT_W-1:0]       WR_count2,
  output logic                   mispredict,
  output logic                   init_done
);

  localparam int IW = INDEX_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_TWO  = IW'(2);
  localparam logic [IW-1:0] IDX_LAST = IW'((2**IW) - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW:0] OCC_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] OCC_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q;
  logic [IW-1:0]     init_idx_q;
  logic [IW-1:0]     ghr_q, ghr_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       occ_q;

  logic [IW-1:0]     idx_mem  [FIFO_DEPTH];
  logic [CNT_W-1:0]  cnt_mem  [FIFO_DEPTH];
  logic              pred_mem [FIFO_DEPTH];
  logic [IW-1:0]     ghr_mem  [FIFO_DEPTH];

  logic              we1_q, we2_q, mis_q;
  logic [IW-1:0]     wi1_q, wi2_q;
  logic [CNT_W-1:0]  wc1_q, wc2_q, cnt_upd;

  logic run, full, empty, accept, pop, mis, clear, push;
  logic [IW-1:0]    h_idx, h_ghr;
  logic [CNT_W-1:0] h_cnt;
  logic             h_pred;

  logic unused_pc;
  assign unused_pc = ^{pc_in[31:IW+2], pc_in[1:0]};

  assign run   = (state_q == RUN);
  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  assign RD_index      = pc_in[IW+1:2] ^ ghr_q;
  assign predict_taken = lookup_valid & RD_count[CNT_W-1];
  assign lookup_ready  = run & ~full;

  assign h_idx  = idx_mem[rd_ptr_q];
  assign h_cnt  = cnt_mem[rd_ptr_q];
  assign h_pred = pred_mem[rd_ptr_q];
  assign h_ghr  = ghr_mem[rd_ptr_q];

  assign accept = lookup_valid & lookup_ready;
  assign pop    = run & resolve_valid & ~empty;
  assign mis    = pop & (h_pred != resolve_taken);
  // Recovery empties the FIFO and drops any same-cycle push.
  assign clear  = run & (mis | flush);
  assign push   = accept & ~clear;

  always_comb begin
    cnt_upd = h_cnt;
    if (resolve_taken && h_cnt != CNT_MAX)
      cnt_upd = h_cnt + CNT_ONE;
    else if (!resolve_taken && h_cnt != '0)
      cnt_upd = h_cnt - CNT_ONE;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (pop && (mis || flush))
      ghr_d = {h_ghr[IW-2:0], resolve_taken};
    else if (run && flush && !empty)
      ghr_d = h_ghr;
    else if (push)
      ghr_d = {ghr_q[IW-2:0], predict_taken};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_q]  <= RD_index;
      cnt_mem[wr_ptr_q]  <= RD_count;
      pred_mem[wr_ptr_q] <= predict_taken;
      ghr_mem[wr_ptr_q]  <= ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      wi1_q      <= '0;
      wi2_q      <= '0;
      wc1_q      <= '0;
      wc2_q      <= '0;
      mis_q      <= 1'b0;
    end else if (state_q == INIT) begin
      we1_q      <= 1'b1;
      wi1_q      <= init_idx_q;
      wc1_q      <= CNT_ONE;
      we2_q      <= 1'b1;
      wi2_q      <= init_idx_q + IDX_ONE;
      wc2_q      <= CNT_ONE;
      mis_q      <= 1'b0;
      init_idx_q <= init_idx_q + IDX_TWO;
      if (init_idx_q == IDX_LAST)
        state_q <= RUN;
    end else begin
      we1_q <= pop;
      we2_q <= 1'b0;
      mis_q <= mis;
      if (pop) begin
        wi1_q <= h_idx;
        wc1_q <= cnt_upd;
      end
      ghr_q <= ghr_d;
      if (clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        if (push)
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (push && !pop)
          occ_q <= occ_q + OCC_ONE;
        else if (pop && !push)
          occ_q <= occ_q - OCC_ONE;
      end
    end
  end

  assign WR_en1     = we1_q;
  assign WR_en2     = we2_q;
  assign WR_index1  = wi1_q;
  assign WR_index2  = wi2_q;
  assign WR_count1  = wc1_q;
  assign WR_count2  = wc2_q;
  assign mispredict = mis_q;
  assign init_done  = run;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Testbench for branch_predict_ctrl: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_branch_predict_ctrl;

  localparam int IW = 8;
  localparam int CW = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [31:0]   pc_in;
  logic          lookup_valid, lookup_ready, predict_taken;
  logic [IW-1:0] RD_index;
  logic [CW-1:0] RD_count;
  logic          resolve_valid, resolve_taken, flush;
  logic          WR_en1, WR_en2;
  logic [IW-1:0] WR_index1, WR_index2;
  logic [CW-1:0] WR_count1, WR_count2;
  logic          mispredict, init_done;

  branch_predict_ctrl #(
    .INDEX_WIDTH(IW), .CNT_W(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .predict_taken(predict_taken), .RD_index(RD_index),
    .RD_count(RD_count), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .flush(flush),
    .WR_en1(WR_en1), .WR_en2(WR_en2),
    .WR_index1(WR_index1), .WR_index2(WR_index2),
    .WR_count1(WR_count1), .WR_count2(WR_count2),
    .mispredict(mispredict), .init_done(init_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: in-flight branches as a queue.
  typedef struct {
    logic [IW-1:0] idx;
    int            cnt;
    bit            pred;
    logic [IW-1:0] ghr;
  } ent_t;

  ent_t          m_q[$];
  bit            m_run  = 1'b0;
  int            m_init = 0;
  logic [IW-1:0] m_ghr  = '0;
  bit            e_we1, e_we2, e_mis;
  int            e_wi1, e_wc1, e_wi2, e_wc2;

  task automatic step(input bit rst, input logic [31:0] pc,
                      input bit lv, input logic [CW-1:0] rdc,
                      input bit rv, input bit rt, input bit fl);
    logic [IW-1:0] idx;
    bit   pred, acc, pop;
    ent_t h;
    rst_n = rst; pc_in = pc; lookup_valid = lv; RD_count = rdc;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    #1;
    idx  = pc[IW+1:2] ^ m_ghr;
    pred = lv & rdc[CW-1];
    acc  = m_run && lv && (m_q.size() < FD);
    chk("rd_index", 32'(RD_index), 32'(idx));
    chk("predict_taken", 32'(predict_taken), 32'(pred));
    chk("lookup_ready", 32'(lookup_ready),
        32'(m_run && (m_q.size() < FD)));
    chk("init_done", 32'(init_done), 32'(m_run));
    if (!rst) begin
      m_run = 0; m_init = 0; m_ghr = '0; m_q.delete();
      e_we1 = 0; e_we2 = 0; e_mis = 0;
    end else if (!m_run) begin
      e_we1 = 1; e_wi1 = m_init; e_wc1 = 1;
      e_we2 = 1; e_wi2 = m_init + 1; e_wc2 = 1;
      e_mis = 0;
      m_init += 2;
      if (m_init == (1 << IW)) m_run = 1;
    end else begin
      pop   = rv && (m_q.size() > 0);
      e_we1 = pop; e_we2 = 0; e_mis = 0;
      if (pop) begin
        h     = m_q[0];
        e_wi1 = h.idx;
        e_wc1 = rt ? ((h.cnt < 3) ? h.cnt + 1 : 3)
                   : ((h.cnt > 0) ? h.cnt - 1 : 0);
        e_mis = (h.pred != rt);
      end
      if (pop && (e_mis || fl)) begin
        m_ghr = {h.ghr[IW-2:0], rt};
        m_q.delete();
      end else if (fl) begin
        if (m_q.size() > 0) m_ghr = m_q[0].ghr;
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (acc) begin
          m_q.push_back('{idx: idx, cnt: int'(rdc),
                          pred: pred, ghr: m_ghr});
          m_ghr = {m_ghr[IW-2:0], pred};
        end
      end
    end
    @(negedge clk);
    chk("wr_en1", 32'(WR_en1), 32'(e_we1));
    if (e_we1) begin
      chk("wr_index1", 32'(WR_index1), 32'(e_wi1));
      chk("wr_count1", 32'(WR_count1), 32'(e_wc1));
    end
    chk("wr_en2", 32'(WR_en2), 32'(e_we2));
    if (e_we2) begin
      chk("wr_index2", 32'(WR_index2), 32'(e_wi2));
      chk("wr_count2", 32'(WR_count2), 32'(e_wc2));
    end
    chk("mispredict", 32'(mispredict), 32'(e_mis));
  endtask

  task automatic idle();
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive combinational inputs only; caller checks before the edge.
  task automatic peek(input logic [31:0] pc, input bit lv,
                      input logic [CW-1:0] rdc);
    rst_n = 1'b1; pc_in = pc; lookup_valid = lv; RD_count = rdc;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic rand_init_sweep();
    for (int i = 0; i < (1 << (IW - 1)); i++)
      step(1'b1, $urandom, 1'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  typedef struct {
    logic [31:0]   pc;
    bit            lv;
    logic [CW-1:0] rdc;
    logic [IW-1:0] exp_idx;
    bit            exp_pred;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b1, 2'd2, 8'h04, 1'b1};
    vecs[1] = '{32'h0000_0000, 1'b1, 2'd1, 8'h00, 1'b0};
    vecs[2] = '{32'h0000_03FC, 1'b0, 2'd3, 8'hFF, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 2'd3, 8'hFF, 1'b1};
    vecs[4] = '{32'h0000_0400, 1'b1, 2'd2, 8'h00, 1'b1};
    vecs[5] = '{32'h1234_5678, 1'b0, 2'd2, 8'h9E, 1'b0};

    rst_n = 1'b0; pc_in = '0; lookup_valid = 1'b0; RD_count = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en1", 32'(WR_en1), 32'd0);
    chk("rst_wr_en2", 32'(WR_en2), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_lookup_ready", 32'(lookup_ready), 32'd0);

    // Sweep with random traffic that must be ignored.
    step(1'b1, 32'h0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("sweep_first_idx1", 32'(WR_index1), 32'd0);
    chk("sweep_first_idx2", 32'(WR_index2), 32'd1);
    for (int i = 1; i < (1 << (IW - 1)); i++)
      step(1'b1, $urandom, 1'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    chk("sweep_last_idx2", 32'(WR_index2), 32'd255);
    chk("sweep_done", 32'(init_done), 32'd1);
    chk("sweep_ready", 32'(lookup_ready), 32'd1);

    foreach (vecs[i]) begin
      peek(vecs[i].pc, vecs[i].lv, vecs[i].rdc);
      chk("vec_rd_index", 32'(RD_index), 32'(vecs[i].exp_idx));
      chk("vec_predict", 32'(predict_taken), 32'(vecs[i].exp_pred));
      idle();
    end

    // First lookup shifts a taken prediction into ghr.
    step(1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    peek(32'h0, 1'b0, 2'd0);
    chk("ghr_after_lookup", 32'(RD_index), 32'h01);
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("resolve_idx", 32'(WR_index1), 32'h04);
    chk("resolve_inc", 32'(WR_count1), 32'd3);

    // Saturation at both ends.
    step(1'b1, 32'h20, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("sat_hi_count", 32'(WR_count1), 32'd3);
    chk("sat_hi_mis", 32'(mispredict), 32'd0);
    step(1'b1, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_lo_count", 32'(WR_count1), 32'd0);
    chk("sat_lo_mis", 32'(mispredict), 32'd0);

    // Full FIFO refuses a lookup even with a same-cycle pop.
    for (int i = 0; i < FD; i++)
      step(1'b1, $urandom, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    peek(32'h40, 1'b1, 2'd2);
    chk("full_ready", 32'(lookup_ready), 32'd0);
    step(1'b1, 32'h40, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    peek(32'h0, 1'b0, 2'd0);
    chk("occ3_ready", 32'(lookup_ready), 32'd1);
    step(1'b1, 32'h44, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    peek(32'h0, 1'b0, 2'd0);
    chk("refill_ready", 32'(lookup_ready), 32'd0);
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Build ghr = 0x05 with push/correct-pop pairs.
    for (int b = IW - 1; b >= 0; b--) begin
      logic [7:0] pat;
      bit bt;
      pat = 8'h05;
      bt  = pat[b];
      step(1'b1, 32'h0, 1'b1, {bt, 1'b0}, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0, 1'b0, 2'd0, 1'b1, bt, 1'b0);
    end
    peek(32'h0, 1'b0, 2'd0);
    chk("ghr_built", 32'(RD_index), 32'h05);
    step(1'b1, 32'h0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("mis_pulse", 32'(mispredict), 32'd1);
    peek(32'h0, 1'b0, 2'd0);
    chk("mis_ghr", 32'(RD_index), 32'h0A);
    chk("mis_empty", 32'(lookup_ready), 32'd1);
    idle();
    chk("mis_pulse_end", 32'(mispredict), 32'd0);

    // Reset mid-RUN with three in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("rerst_done", 32'(init_done), 32'd0);
    chk("rerst_we1", 32'(WR_en1), 32'd0);
    idle();
    chk("rerst_idx1", 32'(WR_index1), 32'd0);
    chk("rerst_idx2", 32'(WR_index2), 32'd1);
    for (int i = 1; i < (1 << (IW - 1)); i++) idle();
    chk("rerst_run", 32'(init_done), 32'd1);

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 2000; i++) begin
      bit r;
      r = ($urandom_range(0, 499) != 0);
      step(r, $urandom, 1'($urandom), 2'($urandom),
           ($urandom_range(0, 2) == 0), 1'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    if (!m_run) rand_init_sweep();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
